// File: rtl/mem_stage_lsu_if.sv
// Request/response channel between the EX/MEM pipeline register and the MEM-stage LSU.
// master = pipeline side, slave = LSU side.
interface mem_stage_lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic            ReqValid;
    logic            ReqReady;
    logic [XLEN-1:0] ReqAddr;
    logic [XLEN-1:0] ReqData;
    logic            ReqWr;
    logic [2:0]      ReqCtrl;
    logic            Stall;
    logic            RspValid;
    logic [XLEN-1:0] RspData;
    logic            RspFault;

    modport master (
        output ReqValid, ReqAddr, ReqData, ReqWr, ReqCtrl,
        input  ReqReady, Stall, RspValid, RspData, RspFault
    );

    modport slave (
        input  ReqValid, ReqAddr, ReqData, ReqWr, ReqCtrl,
        output ReqReady, Stall, RspValid, RspData, RspFault
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one request at a time to a big-endian byte memory; misaligned
// H/W accesses are split into byte accesses, or trapped when MISALIGN_TRAP_EN is defined.
module mem_stage_lsu #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    mem_stage_lsu_if.slave  lsu,
    output logic [XLEN-1:0] Address,
    output logic [XLEN-1:0] DataWr,
    output logic            DMWr,
    output logic [2:0]      DMCtrl,
    input  logic [XLEN-1:0] DataRd
);
    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

    state_t          state_q, state_d;

    logic [XLEN-1:0] addr_q, data_q;
    logic            wr_q;
    logic [2:0]      ctrl_q;
    logic [1:0]      idx_q, idx_d;
    logic [XLEN-9:0] acc_q, acc_d;

    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic [XLEN-1:0] address_d, datawr_d;
    logic            dmwr_d;
    logic [2:0]      dmctrl_d;
`ifdef MISALIGN_TRAP_EN
    logic            rsp_fault_q, rsp_fault_d;
`endif

    logic            accept;
    logic [XLEN-1:0] cur_addr, cur_data;
    logic            cur_wr;
    logic [2:0]      cur_ctrl;
    logic            ctrl_ok, misaligned;
    logic [1:0]      last_idx, nidx, byte_sel;
    logic [7:0]      st_byte;
    logic [XLEN-1:0] ld_raw;

    // Sign/zero extension of the assembled big-endian load value
    function automatic logic [XLEN-1:0] extend(input logic [2:0] ctrl, input logic [XLEN-1:0] raw);
        case (ctrl)
            CTRL_B:  extend = {{(XLEN-8){raw[7]}}, raw[7:0]};
            CTRL_H:  extend = {{(XLEN-16){raw[15]}}, raw[15:0]};
            CTRL_BU: extend = {{(XLEN-8){1'b0}}, raw[7:0]};
            CTRL_HU: extend = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    assign accept = (state_q == S_IDLE) && lsu.ReqValid;

    // In IDLE decode the live request; afterwards only the latched copy is used
    always_comb begin
        cur_addr = addr_q;
        cur_data = data_q;
        cur_wr   = wr_q;
        cur_ctrl = ctrl_q;
        if (state_q == S_IDLE) begin
            cur_addr = lsu.ReqAddr - XLEN'(BASE_ADDR);
            cur_data = lsu.ReqData;
            cur_wr   = lsu.ReqWr;
            cur_ctrl = lsu.ReqCtrl;
        end
    end

    always_comb begin
        ctrl_ok = 1'b0;
        case (cur_ctrl)
            CTRL_B, CTRL_H, CTRL_W, CTRL_BU, CTRL_HU: ctrl_ok = 1'b1;
            default:                                  ctrl_ok = 1'b0;
        endcase
    end

    assign misaligned = ctrl_ok &&
                        (((cur_ctrl[1:0] == 2'b01) && cur_addr[0]) ||
                         ((cur_ctrl[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00)));
    assign last_idx   = (cur_ctrl[1:0] == 2'b10) ? 2'd3 : 2'd1;
    assign nidx       = (state_q == S_SPLIT) ? 2'(idx_q + 2'd1) : 2'd0;
    assign byte_sel   = 2'(last_idx - nidx);
    assign ld_raw     = (state_q == S_SPLIT) ? {acc_q, DataRd[7:0]} : DataRd;

    // Most significant byte goes to the lowest address
    always_comb begin
        st_byte = cur_data[7:0];
        case (byte_sel)
            2'd0:    st_byte = cur_data[7:0];
            2'd1:    st_byte = cur_data[15:8];
            2'd2:    st_byte = cur_data[23:16];
            default: st_byte = cur_data[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (lsu.ReqValid) begin
                    if (!ctrl_ok) begin
                        state_d = S_RESP;
                    end else if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
                        state_d = S_RESP;
`else
                        state_d = S_SPLIT;
`endif
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_SPLIT:  if (idx_q == last_idx) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    always_comb begin
        address_d   = Address;
        datawr_d    = DataWr;
        dmctrl_d    = DMCtrl;
        dmwr_d      = 1'b0;
        idx_d       = idx_q;
        acc_d       = acc_q;
        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        rsp_data_d  = '0;
`ifdef MISALIGN_TRAP_EN
        rsp_fault_d = 1'b0;
`endif
        if (accept)                  acc_d = '0;
        else if (state_q == S_SPLIT) acc_d = {acc_q[XLEN-17:0], DataRd[7:0]};

        case (state_d)
            S_ACCESS: begin
                address_d = cur_addr;
                datawr_d  = cur_data;
                dmctrl_d  = cur_ctrl;
                dmwr_d    = cur_wr;
            end
            S_SPLIT: begin
                address_d = cur_addr + XLEN'(nidx);
                datawr_d  = cur_wr ? {{(XLEN-8){1'b0}}, st_byte} : '0;
                dmctrl_d  = cur_wr ? CTRL_B : CTRL_BU;
                dmwr_d    = cur_wr;
                idx_d     = nidx;
            end
            S_RESP: begin
                if (!cur_wr && (state_q != S_IDLE)) rsp_data_d = extend(cur_ctrl, ld_raw);
`ifdef MISALIGN_TRAP_EN
                if (state_q == S_IDLE) rsp_fault_d = misaligned;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            ctrl_q      <= CTRL_BU;
            idx_q       <= 2'd0;
            acc_q       <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            Address     <= '0;
            DataWr      <= '0;
            DMWr        <= 1'b0;
            DMCtrl      <= CTRL_BU;
`ifdef MISALIGN_TRAP_EN
            rsp_fault_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_q <= cur_addr;
                data_q <= cur_data;
                wr_q   <= cur_wr;
                ctrl_q <= cur_ctrl;
            end
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            Address     <= address_d;
            DataWr      <= datawr_d;
            DMWr        <= dmwr_d;
            DMCtrl      <= dmctrl_d;
`ifdef MISALIGN_TRAP_EN
            rsp_fault_q <= rsp_fault_d;
`endif
        end
    end

    assign lsu.ReqReady = ready_q;
    assign lsu.Stall    = lsu.ReqValid & ~ready_q;
    assign lsu.RspValid = rsp_valid_q;
    assign lsu.RspData  = rsp_data_q;
`ifdef MISALIGN_TRAP_EN
    assign lsu.RspFault = rsp_fault_q;
`else
    assign lsu.RspFault = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed, table-driven bench for mem_stage_lsu with a big-endian byte memory model.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address, DataWr, DataRd;
    logic        DMWr;
    logic [2:0]  DMCtrl;

    mem_stage_lsu_if #(.XLEN(32)) bus ();

    mem_stage_lsu dut (
        .clk     (clk),
        .rst     (rst),
        .lsu     (bus),
        .Address (Address),
        .DataWr  (DataWr),
        .DMWr    (DMWr),
        .DMCtrl  (DMCtrl),
        .DataRd  (DataRd)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic       mem_clr = 1'b0;
    int         nwr = 0;
    logic [7:0] a0, a1, a2, a3;
    assign a0 = Address[7:0];
    assign a1 = 8'(a0 + 8'd1);
    assign a2 = 8'(a0 + 8'd2);
    assign a3 = 8'(a0 + 8'd3);

    always_comb begin
        case (DMCtrl[1:0])
            2'b00:   DataRd = {24'h0, mem[a0]};
            2'b01:   DataRd = {16'h0, mem[a0], mem[a1]};
            default: DataRd = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (DMWr) begin
            nwr <= nwr + 1;
            case (DMCtrl[1:0])
                2'b00: mem[a0] <= DataWr[7:0];
                2'b01: begin mem[a0] <= DataWr[15:8]; mem[a1] <= DataWr[7:0]; end
                default: begin
                    mem[a0] <= DataWr[31:24]; mem[a1] <= DataWr[23:16];
                    mem[a2] <= DataWr[15:8];  mem[a3] <= DataWr[7:0];
                end
            endcase
        end
    end

    typedef struct {
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
        int          nw;
        logic        mis;
        logic [31:0] texp;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [NV];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic do_req(input int n, input vec_t v);
        int          lat;
        int          nw0;
        logic [31:0] edata;
        int          elat, enw;
        logic        efault;
        edata  = v.exp;
        elat   = v.lat;
        enw    = v.nw;
        efault = 1'b0;
`ifdef MISALIGN_TRAP_EN
        edata = v.texp;
        if (v.mis) begin elat = 1; enw = 0; efault = 1'b1; edata = 32'h0; end
`endif
        @(negedge clk);
        chk($sformatf("v%0d_ready", n), 32'(bus.ReqReady), 32'd1);
        bus.ReqValid = 1'b1;
        bus.ReqWr    = v.wr;
        bus.ReqCtrl  = v.ctrl;
        bus.ReqAddr  = v.addr;
        bus.ReqData  = v.data;
        nw0 = nwr;
        @(posedge clk); #1;
        bus.ReqValid = 1'b0;
        bus.ReqWr    = ~v.wr;
        bus.ReqCtrl  = 3'b011;
        bus.ReqAddr  = $urandom;
        bus.ReqData  = $urandom;
        lat = 0;
        while (!bus.RspValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_rsp_seen", n), 32'(bus.RspValid), 32'd1);
        chk($sformatf("v%0d_latency", n), 32'(lat + 1), 32'(elat));
        chk($sformatf("v%0d_data", n), bus.RspData, edata);
        chk($sformatf("v%0d_fault", n), 32'(bus.RspFault), 32'(efault));
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse", n), 32'(bus.RspValid), 32'd0);
        chk($sformatf("v%0d_ready_back", n), 32'(bus.ReqReady), 32'd1);
        chk($sformatf("v%0d_writes", n), 32'(nwr - nw0), 32'(enw));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          nw0;
        logic        seen;
        logic [5:0]  rv_pat, st_pat;
        logic [31:0] d1, d4;
        logic [7:0]  e21, e22, e23, e24, e51, e52;
        int          esplit;

        //       wr    ctrl    addr          data          exp           lat nw mis   texp
        vt[0]  = '{1'b1, 3'b010, 32'h00000010, 32'hA1B2C3D4, 32'h00000000, 2, 1, 1'b0, 32'h00000000};
        vt[1]  = '{1'b0, 3'b010, 32'h00000010, 32'h0,        32'hA1B2C3D4, 2, 0, 1'b0, 32'hA1B2C3D4};
        vt[2]  = '{1'b0, 3'b000, 32'h00000010, 32'h0,        32'hFFFFFFA1, 2, 0, 1'b0, 32'hFFFFFFA1};
        vt[3]  = '{1'b0, 3'b100, 32'h00000010, 32'h0,        32'h000000A1, 2, 0, 1'b0, 32'h000000A1};
        vt[4]  = '{1'b0, 3'b001, 32'h00000012, 32'h0,        32'hFFFFC3D4, 2, 0, 1'b0, 32'hFFFFC3D4};
        vt[5]  = '{1'b0, 3'b101, 32'h00000012, 32'h0,        32'h0000C3D4, 2, 0, 1'b0, 32'h0000C3D4};
        vt[6]  = '{1'b1, 3'b010, 32'h00000021, 32'h11223344, 32'h00000000, 5, 4, 1'b1, 32'h00000000};
        vt[7]  = '{1'b0, 3'b010, 32'h00000021, 32'h0,        32'h11223344, 5, 0, 1'b1, 32'h00000000};
        vt[8]  = '{1'b0, 3'b010, 32'h00000020, 32'h0,        32'h00112233, 2, 0, 1'b0, 32'h00000000};
        vt[9]  = '{1'b1, 3'b000, 32'h00000033, 32'hFFFFFF80, 32'h00000000, 2, 1, 1'b0, 32'h00000000};
        vt[10] = '{1'b1, 3'b000, 32'h00000034, 32'h12345601, 32'h00000000, 2, 1, 1'b0, 32'h00000000};
        vt[11] = '{1'b0, 3'b001, 32'h00000033, 32'h0,        32'hFFFF8001, 3, 0, 1'b1, 32'h00000000};
        vt[12] = '{1'b0, 3'b101, 32'h00000033, 32'h0,        32'h00008001, 3, 0, 1'b1, 32'h00000000};
        vt[13] = '{1'b1, 3'b111, 32'h00000040, 32'hDEADBEEF, 32'h00000000, 1, 0, 1'b0, 32'h00000000};
        vt[14] = '{1'b0, 3'b011, 32'h00000010, 32'h0,        32'h00000000, 1, 0, 1'b0, 32'h00000000};
        vt[15] = '{1'b1, 3'b001, 32'h00000041, 32'h0000BEEF, 32'h00000000, 3, 2, 1'b1, 32'h00000000};
        vt[16] = '{1'b0, 3'b101, 32'h00000041, 32'h0,        32'h0000BEEF, 3, 0, 1'b1, 32'h00000000};
        vt[17] = '{1'b0, 3'b000, 32'h00000042, 32'h0,        32'hFFFFFFEF, 2, 0, 1'b0, 32'h00000000};
        vt[18] = '{1'b1, 3'b010, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h00000000, 5, 4, 1'b1, 32'h00000000};
        vt[19] = '{1'b0, 3'b010, 32'hFFFFFFFF, 32'h0,        32'hCAFEF00D, 5, 0, 1'b1, 32'h00000000};
        vt[20] = '{1'b0, 3'b100, 32'h00000000, 32'h0,        32'h000000FE, 2, 0, 1'b0, 32'h00000000};
        vt[21] = '{1'b0, 3'b101, 32'h00000001, 32'h0,        32'h0000F00D, 3, 0, 1'b1, 32'h00000000};
        vt[22] = '{1'b1, 3'b110, 32'h00000044, 32'h12345678, 32'h00000000, 1, 0, 1'b0, 32'h00000000};
        vt[23] = '{1'b1, 3'b001, 32'h00000060, 32'h0000ABCD, 32'h00000000, 2, 1, 1'b0, 32'h00000000};
        vt[24] = '{1'b0, 3'b010, 32'h00000060, 32'h0,        32'hABCD0000, 2, 0, 1'b0, 32'hABCD0000};

        bus.ReqValid = 1'b0;
        bus.ReqWr    = 1'b0;
        bus.ReqCtrl  = 3'b000;
        bus.ReqAddr  = 32'h0;
        bus.ReqData  = 32'h0;
        rst     = 1'b1;
        mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",    32'(bus.ReqReady), 32'd1);
        chk("rst_rspvalid", 32'(bus.RspValid), 32'd0);
        chk("rst_fault",    32'(bus.RspFault), 32'd0);
        chk("rst_rspdata",  bus.RspData,       32'h0);
        chk("rst_dmwr",     32'(DMWr),         32'd0);
        chk("rst_address",  Address,           32'h0);
        chk("rst_datawr",   DataWr,            32'h0);
        chk("rst_dmctrl",   32'(DMCtrl),       32'(3'b100));
        chk("rst_stall",    32'(bus.Stall),    32'd0);
        rst     = 1'b0;
        mem_clr = 1'b0;

        for (int i = 0; i < NV; i++) do_req(i, vt[i]);

`ifdef MISALIGN_TRAP_EN
        e21 = 8'h00; e22 = 8'h00; e23 = 8'h00; e24 = 8'h00;
`else
        e21 = 8'h11; e22 = 8'h22; e23 = 8'h33; e24 = 8'h44;
`endif
        chk("mem_10", 32'(mem[8'h10]), 32'h A1);
        chk("mem_11", 32'(mem[8'h11]), 32'h B2);
        chk("mem_12", 32'(mem[8'h12]), 32'h C3);
        chk("mem_13", 32'(mem[8'h13]), 32'h D4);
        chk("mem_21", 32'(mem[8'h21]), 32'(e21));
        chk("mem_22", 32'(mem[8'h22]), 32'(e22));
        chk("mem_23", 32'(mem[8'h23]), 32'(e23));
        chk("mem_24", 32'(mem[8'h24]), 32'(e24));
        chk("mem_40_untouched", 32'(mem[8'h40]), 32'h0);
        chk("mem_44_untouched", 32'(mem[8'h44]), 32'h0);

        // Back-to-back aligned loads with ReqValid held high
        @(negedge clk);
        bus.ReqValid = 1'b1;
        bus.ReqWr    = 1'b0;
        bus.ReqCtrl  = 3'b010;
        bus.ReqAddr  = 32'h10;
        bus.ReqData  = 32'h0;
        rv_pat = '0;
        st_pat = '0;
        d1 = 32'h0;
        d4 = 32'h0;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            rv_pat[s] = bus.RspValid;
            st_pat[s] = bus.Stall;
            if (s == 1) d1 = bus.RspData;
            if (s == 4) d4 = bus.RspData;
        end
        bus.ReqValid = 1'b0;
        chk("b2b_rspvalid_pattern", 32'(rv_pat), 32'(6'b010010));
        chk("b2b_stall_pattern",    32'(st_pat), 32'(6'b011011));
        chk("b2b_data_first",  d1, 32'hA1B2C3D4);
        chk("b2b_data_second", d4, 32'hA1B2C3D4);
        @(posedge clk); #1;

        // Reset during a split word store, after two bytes have gone out
        @(negedge clk);
        bus.ReqValid = 1'b1;
        bus.ReqWr    = 1'b1;
        bus.ReqCtrl  = 3'b010;
        bus.ReqAddr  = 32'h51;
        bus.ReqData  = 32'h55667788;
        nw0 = nwr;
        @(posedge clk); #1;
        bus.ReqValid = 1'b0;
`ifndef MISALIGN_TRAP_EN
        chk("split_first_dmwr",   32'(DMWr),   32'd1);
        chk("split_first_addr",   Address,     32'h51);
        chk("split_first_dmctrl", 32'(DMCtrl), 32'(3'b000));
        chk("split_first_datawr", DataWr,      32'h55);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_dmwr",     32'(DMWr),         32'd0);
        chk("midrst_ready",    32'(bus.ReqReady), 32'd1);
        chk("midrst_rspvalid", 32'(bus.RspValid), 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            if (bus.RspValid) seen = 1'b1;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
`ifdef MISALIGN_TRAP_EN
        esplit = 0; e51 = 8'h00; e52 = 8'h00;
`else
        esplit = 2; e51 = 8'h55; e52 = 8'h66;
`endif
        chk("midrst_writes", 32'(nwr - nw0), 32'(esplit));
        chk("mem_51", 32'(mem[8'h51]), 32'(e51));
        chk("mem_52", 32'(mem[8'h52]), 32'(e52));
        chk("mem_53", 32'(mem[8'h53]), 32'h0);
        chk("mem_54", 32'(mem[8'h54]), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
